// File: rtl/fuzzy_risk_engine.sv
// Two-input Mamdani fuzzy risk estimator: programmable triangular sets, min/product rule AND,
// weighted-average defuzzification through a shared restoring divider (one quotient bit per cycle).
module fuzzy_risk_engine #(
    parameter int W        = 8,
    parameter int MW       = 8,
    parameter int OUT_W    = 8,
    parameter int AND_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     rain_fall,
    input  logic [W-1:0]     soil_moisture,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] risk,
    output logic             out_zero,
    output logic             busy,
    input  logic             cfg_we,
    input  logic [4:0]       cfg_addr,
    input  logic [15:0]      cfg_data,
    output logic             cfg_err
);
    localparam int NW = MW + OUT_W + 2;
    localparam int DW = MW + 2;
    localparam int CW = $clog2(OUT_W + 1);
    localparam logic [MW-1:0] GMAX = {MW{1'b1}};
    localparam logic [8:0][W-1:0] SET_DEF = {W'(8'd100), W'(8'd80), W'(8'd60),
                                             W'(8'd70),  W'(8'd50), W'(8'd30),
                                             W'(8'd40),  W'(8'd20), W'(8'd0)};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_FUZZ = 3'd1,
        S_RULE = 3'd2,
        S_SUM  = 3'd3,
        S_DIV  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t                  state_r;
    logic [17:0][W-1:0]      bp_r;
    logic [2:0][OUT_W-1:0]   cons_r;
    logic [W-1:0]            rain_r, soil_r;
    logic [5:0][MW-1:0]      grade_s, grade_r;
    logic [2:0][MW-1:0]      str_s, str_r;
    logic [NW-1:0]           num_s, num_r, rem_r, dsh_r;
    logic [DW-1:0]           den_s, den_r;
    logic [OUT_W-1:0]        quo_r, risk_r;
    logic [CW-1:0]           cnt_r;
    logic                    ge_s;
    logic                    in_ready_r, out_valid_r, out_zero_r, busy_r, cfg_err_r;

    // Triangular membership with truncating interpolation; malformed sets never fire.
    function automatic logic [MW-1:0] grade(input logic [W-1:0] v, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W+MW-1:0] prod;
        logic [W-1:0]    span;
        logic [MW-1:0]   g;
        prod = '0;
        span = '1;
        if (a > b || b > c) begin
            g = '0;
        end else if (v == b) begin
            g = GMAX;
        end else if (v <= a || v >= c) begin
            g = '0;
        end else if (v < b) begin
            prod = (W+MW)'(v - a) * (W+MW)'(GMAX);
            span = b - a;
            g    = MW'(prod / (W+MW)'(span));
        end else begin
            prod = (W+MW)'(c - v) * (W+MW)'(GMAX);
            span = c - b;
            g    = MW'(prod / (W+MW)'(span));
        end
        return g;
    endfunction

    function automatic logic [MW-1:0] fuzzy_and(input logic [MW-1:0] r, input logic [MW-1:0] s);
        logic [2*MW-1:0] p;
        logic [MW-1:0]   g;
        p = (2*MW)'(r) * (2*MW)'(s);
        if (AND_MODE == 1) begin
            g = p[2*MW-1:MW];
        end else if (r < s) begin
            g = r;
        end else begin
            g = s;
        end
        return g;
    endfunction

    // Combinational fuzzification, rule evaluation, aggregation and divider compare.
    always_comb begin
        grade_s[0] = grade(rain_r, bp_r[0],  bp_r[1],  bp_r[2]);
        grade_s[1] = grade(rain_r, bp_r[3],  bp_r[4],  bp_r[5]);
        grade_s[2] = grade(rain_r, bp_r[6],  bp_r[7],  bp_r[8]);
        grade_s[3] = grade(soil_r, bp_r[9],  bp_r[10], bp_r[11]);
        grade_s[4] = grade(soil_r, bp_r[12], bp_r[13], bp_r[14]);
        grade_s[5] = grade(soil_r, bp_r[15], bp_r[16], bp_r[17]);
        str_s[0]   = fuzzy_and(grade_r[0], grade_r[3]);
        str_s[1]   = fuzzy_and(grade_r[1], grade_r[4]);
        str_s[2]   = fuzzy_and(grade_r[2], grade_r[5]);
        num_s      = NW'(str_r[0]) * NW'(cons_r[0]) + NW'(str_r[1]) * NW'(cons_r[1])
                   + NW'(str_r[2]) * NW'(cons_r[2]);
        den_s      = DW'(str_r[0]) + DW'(str_r[1]) + DW'(str_r[2]);
        ge_s       = (rem_r >= dsh_r);
    end

    // Configuration registers; writes are only legal while the engine is idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bp_r      <= {SET_DEF, SET_DEF};
            cons_r[0] <= OUT_W'(8'd85);
            cons_r[1] <= OUT_W'(8'd170);
            cons_r[2] <= OUT_W'(8'd255);
            cfg_err_r <= 1'b0;
        end else begin
            cfg_err_r <= 1'b0;
            if (cfg_we) begin
                if (busy_r || cfg_addr > 5'd20) begin
                    cfg_err_r <= 1'b1;
                end else begin
                    case (cfg_addr)
                        5'd18:   cons_r[0] <= cfg_data[OUT_W-1:0];
                        5'd19:   cons_r[1] <= cfg_data[OUT_W-1:0];
                        5'd20:   cons_r[2] <= cfg_data[OUT_W-1:0];
                        default: bp_r[cfg_addr] <= cfg_data[W-1:0];
                    endcase
                end
            end
        end
    end

    // Transaction FSM with pipeline registers, divider and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            risk_r      <= '0;
            out_zero_r  <= 1'b0;
            busy_r      <= 1'b0;
            rain_r      <= '0;
            soil_r      <= '0;
            grade_r     <= '0;
            str_r       <= '0;
            num_r       <= '0;
            den_r       <= '0;
            rem_r       <= '0;
            dsh_r       <= '0;
            quo_r       <= '0;
            cnt_r       <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid) begin
                        rain_r     <= rain_fall;
                        soil_r     <= soil_moisture;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= S_FUZZ;
                    end
                end
                S_FUZZ: begin
                    grade_r <= grade_s;
                    state_r <= S_RULE;
                end
                S_RULE: begin
                    str_r   <= str_s;
                    state_r <= S_SUM;
                end
                S_SUM: begin
                    num_r   <= num_s;
                    den_r   <= den_s;
                    cnt_r   <= '0;
                    state_r <= S_DIV;
                end
                S_DIV: begin
                    // First DIV cycle loads the shifted divisor; the next OUT_W cycles resolve bits MSB first.
                    if (cnt_r == '0) begin
                        if (den_r == '0) begin
                            risk_r      <= '0;
                            out_zero_r  <= 1'b1;
                            out_valid_r <= 1'b1;
                            state_r     <= S_DONE;
                        end else begin
                            rem_r <= num_r;
                            dsh_r <= NW'(den_r) << (OUT_W - 1);
                            quo_r <= '0;
                            cnt_r <= CW'(1'b1);
                        end
                    end else begin
                        if (ge_s) begin
                            rem_r <= rem_r - dsh_r;
                        end
                        dsh_r <= dsh_r >> 1;
                        quo_r <= {quo_r[OUT_W-2:0], ge_s};
                        if (cnt_r == CW'(OUT_W)) begin
                            risk_r      <= {quo_r[OUT_W-2:0], ge_s};
                            out_zero_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                            state_r     <= S_DONE;
                        end else begin
                            cnt_r <= cnt_r + CW'(1'b1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign risk      = risk_r;
    assign out_zero  = out_zero_r;
    assign busy      = busy_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_fuzzy_risk_engine.sv
// Scoreboard bench: a min-AND and a product-AND engine see identical stimulus; monitors pop expected results.
module tb_fuzzy_risk_engine;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, cfg_we;
    logic [7:0]  rain_fall, soil_moisture;
    logic [4:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic        in_ready_m, out_valid_m, out_zero_m, busy_m, cfg_err_m;
    logic        in_ready_p, out_valid_p, out_zero_p, busy_p, cfg_err_p;
    logic [7:0]  risk_m, risk_p;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int rm;
        int rp;
        int z;
        int lat;
        int acc;
    } exp_t;
    exp_t q_m[$];
    exp_t q_p[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fuzzy_risk_engine #(.W(8), .MW(8), .OUT_W(8), .AND_MODE(0)) u_min (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
        .rain_fall(rain_fall), .soil_moisture(soil_moisture), .out_valid(out_valid_m),
        .out_ready(out_ready), .risk(risk_m), .out_zero(out_zero_m), .busy(busy_m),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err_m));

    fuzzy_risk_engine #(.W(8), .MW(8), .OUT_W(8), .AND_MODE(1)) u_prod (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_p),
        .rain_fall(rain_fall), .soil_moisture(soil_moisture), .out_valid(out_valid_p),
        .out_ready(out_ready), .risk(risk_p), .out_zero(out_zero_p), .busy(busy_p),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_err(cfg_err_p));

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor for the min-AND engine.
    int   rise_m = 0;
    logic prev_m = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_m && !prev_m) rise_m = cyc;
        prev_m = out_valid_m;
        if (out_valid_m && out_ready) begin
            if (q_m.size() == 0) begin
                chk("unexpected_result_min", 1, 0);
            end else begin
                e = q_m.pop_front();
                chk("risk_min", risk_m, e.rm);
                chk("zero_min", out_zero_m, e.z);
                chk("latency_min", rise_m - e.acc, e.lat);
                chk("in_ready_in_done_min", in_ready_m, 0);
            end
        end
    end

    // Monitor for the product-AND engine.
    int   rise_p = 0;
    logic prev_p = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (out_valid_p && !prev_p) rise_p = cyc;
        prev_p = out_valid_p;
        if (out_valid_p && out_ready) begin
            if (q_p.size() == 0) begin
                chk("unexpected_result_prod", 1, 0);
            end else begin
                e = q_p.pop_front();
                chk("risk_prod", risk_p, e.rp);
                chk("zero_prod", out_zero_p, e.z);
                chk("latency_prod", rise_p - e.acc, e.lat);
            end
        end
    end

    task automatic send(input int rain, input int soil, input int rm, input int rp,
                        input int z, input int lat, input bit push);
        exp_t e;
        int   n;
        @(posedge clk); #1;
        rain_fall     = 8'(rain);
        soil_moisture = 8'(soil);
        in_valid      = 1'b1;
        n = 0;
        while (!in_ready_m && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            chk("accept_timeout", 1, 0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            e.rm = rm; e.rp = rp; e.z = z; e.lat = lat; e.acc = cyc;
            if (push) begin
                q_m.push_back(e);
                q_p.push_back(e);
            end
        end
    endtask

    task automatic cfg_write(input int addr, input int data, input int exp_err);
        @(posedge clk); #1;
        cfg_we   = 1'b1;
        cfg_addr = 5'(addr);
        cfg_data = 16'(data);
        @(posedge clk); #1;
        cfg_we = 1'b0;
        chk("cfg_err_pulse", cfg_err_m, exp_err);
        @(posedge clk); #1;
        chk("cfg_err_single_cycle", cfg_err_m, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q_m.size() != 0 || q_p.size() != 0 || !in_ready_m) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cfg_we = 1'b0;
        cfg_addr = 5'd0; cfg_data = 16'd0; rain_fall = 8'd0; soil_moisture = 8'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready", in_ready_m, 1);
        chk("rst_out_valid", out_valid_m, 0);
        chk("rst_risk", risk_m, 0);
        chk("rst_out_zero", out_zero_m, 0);
        chk("rst_busy", busy_m, 0);
        chk("rst_cfg_err", cfg_err_m, 0);

        // Default sets and consequents: rain, soil, risk(min), risk(prod), zero, latency.
        send(80, 80, 255, 255, 0, 12, 1'b1);
        send(35, 35, 127, 127, 0, 12, 1'b1);
        send(50, 50, 170, 170, 0, 12, 1'b1);
        send(20, 90, 0,   0,   1, 4,  1'b1);
        send(10, 10, 85,  85,  0, 12, 1'b1);
        send(35, 38, 145, 153, 0, 12, 1'b1);
        send(60, 40, 170, 170, 0, 12, 1'b1);
        wait_idle();

        // Back-pressure: result held, new samples ignored.
        out_ready = 1'b0;
        send(50, 50, 170, 170, 0, 12, 1'b1);
        in_valid  = 1'b1;
        rain_fall = 8'd80;
        n = 0;
        while (!out_valid_m && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("hold_out_valid_seen", out_valid_m, 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("hold_risk_stable", risk_m, 170);
            chk("hold_out_valid", out_valid_m, 1);
            chk("hold_in_ready_low", in_ready_m, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Consequent reprogramming and rejected writes.
        cfg_write(20, 200, 0);
        send(80, 80, 200, 200, 0, 12, 1'b1);
        wait_idle();
        cfg_write(25, 7, 1);
        send(80, 80, 200, 200, 0, 12, 1'b1);
        cfg_write(20, 50, 1);
        wait_idle();
        send(80, 80, 200, 200, 0, 12, 1'b1);
        wait_idle();

        // Reset in the middle of division: no result, defaults restored.
        send(80, 80, 0, 0, 0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid_m, 0);
        chk("midrst_in_ready", in_ready_m, 1);
        chk("midrst_busy", busy_m, 0);
        chk("midrst_out_valid_prod", out_valid_p, 0);
        rst_n = 1'b1;
        send(80, 80, 255, 255, 0, 12, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
